// File: rtl/fcpu_pkg.sv
// fcpu_pkg: shared widths and helpers for the common data bus (CDB).
//   RSV_ID_W / DATA_W / CDB_W : layout of one CDB word {RSV_ID, DATA}
//   BURST_W                   : width of the priority burst counter (PRIO_BURST <= 15)
//   first_nonprio()           : lowest requester index that is not the priority one
package fcpu_pkg;

    localparam int RSV_ID_W = 4;
    localparam int DATA_W   = 16;
    localparam int CDB_W    = RSV_ID_W + DATA_W;
    localparam int BURST_W  = 4;

    // Round-robin pointer home position after reset or flush.
    function automatic int first_nonprio(input int prio_idx);
        return (prio_idx == 0) ? 1 : 0;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search.
//   mask_i  : request mask (priority requester already removed)
//   ptr_i   : index where the search starts
//   grant_o : one-hot grant of the first set mask bit at or after ptr_i,
//             scanning upward with wrap-around; zero if the mask is empty
module rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] mask_i,
    input  logic [W-1:0] ptr_i,
    output logic [N-1:0] grant_o
);

    logic         found;
    logic [W-1:0] idx;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            idx = W'((int'(ptr_i) + k) % N);
            if (!found && mask_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares one common data bus among N_REQ execution units.
// One requester (PRIO_IDX, the branch unit) wins while its burst counter is
// below PRIO_BURST; the rest are served round-robin. The winning word is
// registered and broadcast one cycle after the handshake.
//   clk, rst             : clock, asynchronous active-high reset
//   clear                : synchronous flush (branch miss)
//   req_data / req_valid : per-requester CDB word and valid (slice i = requester i)
//   req_ready            : per-requester ready, one-hot or zero
//   cdb / cdb_valid      : registered broadcast word and valid
//   cdb_src              : index of the requester that produced cdb
module cdb_arbiter
    import fcpu_pkg::*;
#(
    parameter  int N_REQ      = 4,
    parameter  int PRIO_IDX   = 0,
    parameter  int PRIO_BURST = 2,
    localparam int N_REQ_W    = $clog2(N_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic [N_REQ*CDB_W-1:0]   req_data,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    output logic [CDB_W-1:0]         cdb,
    output logic                     cdb_valid,
    output logic [N_REQ_W-1:0]       cdb_src
);

    localparam logic [N_REQ-1:0]   PRIO_MASK = N_REQ'(1) << PRIO_IDX;
    localparam logic [N_REQ_W-1:0] RR_INIT   = N_REQ_W'(first_nonprio(PRIO_IDX));
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(PRIO_BURST);

    logic [N_REQ-1:0]   rr_ptr_q, rr_ptr_d_unused;
    logic [N_REQ_W-1:0] ptr_q, ptr_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [CDB_W-1:0]   cdb_q;
    logic               cdb_valid_q;
    logic [N_REQ_W-1:0] cdb_src_q;

    logic [N_REQ-1:0]   others_mask;
    logic               others_valid;
    logic               prio_valid;
    logic               prio_win;
    logic [N_REQ-1:0]   rr_grant;
    logic [N_REQ-1:0]   grant;
    logic               transfer;
    logic [N_REQ_W-1:0] g_idx;
    logic [CDB_W-1:0]   sel_word;
    int                 nxt;

    assign rr_ptr_q        = '0;
    assign rr_ptr_d_unused = rr_ptr_q;

    assign others_mask  = req_valid & ~PRIO_MASK;
    assign others_valid = |others_mask;
    assign prio_valid   = req_valid[PRIO_IDX];
    // Priority wins below its burst limit, or when nobody else is asking.
    assign prio_win     = prio_valid && ((burst_q < BURST_MAX) || !others_valid);

    rr_pick #(.N(N_REQ), .W(N_REQ_W)) u_rr_pick (
        .mask_i  (others_mask),
        .ptr_i   (ptr_q),
        .grant_o (rr_grant)
    );

    always_comb begin
        grant = '0;
        if (!rst && !clear) begin
            grant = prio_win ? PRIO_MASK : rr_grant;
        end
    end

    assign req_ready = grant;
    assign transfer  = |grant;

    // Encode the one-hot grant and pick the matching data slice.
    always_comb begin
        g_idx    = '0;
        sel_word = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                g_idx    = N_REQ_W'(i);
                sel_word = req_data[i*CDB_W +: CDB_W];
            end
        end
    end

    always_comb begin
        burst_d = burst_q;
        if (clear || !prio_valid) begin
            burst_d = '0;
        end else if (grant[PRIO_IDX]) begin
            // A lone priority requester neither consumes nor refills its burst.
            if (others_valid && (burst_q < BURST_MAX)) begin
                burst_d = burst_q + 1'b1;
            end
        end else if (transfer) begin
            burst_d = '0;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        nxt   = 0;
        if (clear) begin
            ptr_d = RR_INIT;
        end else if (transfer && !grant[PRIO_IDX]) begin
            nxt = (int'(g_idx) + 1) % N_REQ;
            if (nxt == PRIO_IDX) begin
                nxt = (nxt + 1) % N_REQ;
            end
            ptr_d = N_REQ_W'(nxt);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= RR_INIT;
            burst_q     <= '0;
            cdb_q       <= '0;
            cdb_valid_q <= 1'b0;
            cdb_src_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            burst_q     <= burst_d;
            cdb_valid_q <= transfer;
            if (transfer) begin
                cdb_q     <= sel_word;
                cdb_src_q <= g_idx;
            end
        end
    end

    assign cdb       = cdb_q;
    assign cdb_valid = cdb_valid_q;
    assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed and constrained-random checks of cdb_arbiter
// (N_REQ=4, PRIO_IDX=0, PRIO_BURST=2).
module tb_cdb_arbiter;
    import fcpu_pkg::*;

    localparam int N     = 4;
    localparam int PB    = 2;
    localparam int BOUND = (N - 1) * (PB + 1);

    logic                 clk;
    logic                 rst;
    logic                 clear;
    logic [N*CDB_W-1:0]   req_data;
    logic [N-1:0]         req_valid;
    logic [N-1:0]         req_ready;
    logic [CDB_W-1:0]     cdb;
    logic                 cdb_valid;
    logic [1:0]           cdb_src;

    int                   total;
    int                   bad;
    int                   step;
    logic [CDB_W-1:0]     last_word;
    int                   last_src;

    cdb_arbiter #(.N_REQ(N), .PRIO_IDX(0), .PRIO_BURST(PB)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .req_data  (req_data),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .cdb       (cdb),
        .cdb_valid (cdb_valid),
        .cdb_src   (cdb_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [CDB_W-1:0] word(input int s, input int i);
        return {RSV_ID_W'(i + 1), DATA_W'(s * 16 + i)};
    endfunction

    task automatic set_data(input int s);
        for (int i = 0; i < N; i++) req_data[i*CDB_W +: CDB_W] = word(s, i);
    endtask

    // One directed transaction: drive, check ready, clock, check broadcast.
    task automatic cyc(input logic [N-1:0] v, input logic clr, input logic [N-1:0] exp_rdy,
                       input string tag);
        int g;
        @(negedge clk);
        step++;
        req_valid = v;
        clear     = clr;
        set_data(step);
        #1;
        chk({tag, ".ready"}, 32'(req_ready), 32'(exp_rdy));
        g = 0;
        for (int i = 0; i < N; i++) if (exp_rdy[i]) g = i;
        @(posedge clk);
        #1;
        if (exp_rdy != '0) begin
            last_word = word(step, g);
            last_src  = g;
            chk({tag, ".cdb_valid"}, 32'(cdb_valid), 32'd1);
        end else begin
            chk({tag, ".cdb_valid"}, 32'(cdb_valid), 32'd0);
        end
        chk({tag, ".cdb"}, 32'(cdb), 32'(last_word));
        chk({tag, ".cdb_src"}, 32'(cdb_src), last_src);
        $display("step %0d %s valid=%b clear=%b ready=%b cdb_valid=%b cdb=%h src=%0d",
                 step, tag, v, clr, exp_rdy, cdb_valid, cdb, cdb_src);
        clear = 1'b0;
    endtask

    logic [N-1:0] rv;
    logic [N-1:0] rr;
    logic [N-1:0] gr_prev;
    int           wait_c [N];
    logic [CDB_W-1:0] exp_word;
    int           exp_src;

    initial begin
        total = 0; bad = 0; step = 0;
        last_word = '0; last_src = 0;
        rst = 1'b1; clear = 1'b0; req_valid = '1; req_data = '0;

        // Reset state, with every requester asking.
        #12;
        chk("rst.ready", 32'(req_ready), 32'd0);
        chk("rst.cdb_valid", 32'(cdb_valid), 32'd0);
        chk("rst.cdb", 32'(cdb), 32'd0);
        chk("rst.cdb_src", 32'(cdb_src), 32'd0);
        @(posedge clk); #1;
        chk("rst.edge_valid", 32'(cdb_valid), 32'd0);
        chk("rst.edge_ready", 32'(req_ready), 32'd0);
        @(negedge clk); rst = 1'b0; req_valid = '0;

        // Round robin among non-priority requesters, including wrap-around.
        cyc(4'b1010, 1'b0, 4'b0010, "rr13_a");
        cyc(4'b1010, 1'b0, 4'b1000, "rr13_b");
        cyc(4'b0110, 1'b0, 4'b0010, "rr12_a");
        cyc(4'b0110, 1'b0, 4'b0100, "rr12_b");
        cyc(4'b0110, 1'b0, 4'b0010, "rr12_wrap");

        // Priority burst against one waiting requester: 0,0,2,0,0,2.
        cyc(4'b0101, 1'b0, 4'b0001, "burst_1");
        cyc(4'b0101, 1'b0, 4'b0001, "burst_2");
        cyc(4'b0101, 1'b0, 4'b0100, "burst_3");
        cyc(4'b0101, 1'b0, 4'b0001, "burst_4");
        cyc(4'b0101, 1'b0, 4'b0001, "burst_5");
        cyc(4'b0101, 1'b0, 4'b0100, "burst_6");

        // Lone priority requester: granted every cycle, burst stays at 0.
        for (int k = 0; k < 5; k++) cyc(4'b0001, 1'b0, 4'b0001, "prio_only");
        cyc(4'b0101, 1'b0, 4'b0001, "after_solo_1");
        cyc(4'b0101, 1'b0, 4'b0001, "after_solo_2");
        cyc(4'b0101, 1'b0, 4'b0100, "after_solo_3");

        // Idle: nothing granted, broadcast word held.
        cyc(4'b0000, 1'b0, 4'b0000, "idle_1");
        cyc(4'b0000, 1'b0, 4'b0000, "idle_2");

        // Flush right after a transfer; pointer and burst return home.
        cyc(4'b0010, 1'b0, 4'b0010, "pre_clear");
        cyc(4'b1111, 1'b1, 4'b0000, "clear");
        cyc(4'b1110, 1'b0, 4'b0010, "post_clear_rr");
        cyc(4'b0101, 1'b0, 4'b0001, "cb_1");
        cyc(4'b0101, 1'b1, 4'b0000, "cb_clear");
        cyc(4'b0101, 1'b0, 4'b0001, "cb_2");
        cyc(4'b0101, 1'b0, 4'b0001, "cb_3");
        cyc(4'b0101, 1'b0, 4'b0100, "cb_4");

        // Asynchronous reset between edges while a word is on the bus.
        @(negedge clk);
        step++;
        req_valid = 4'b0010;
        set_data(step);
        @(posedge clk); #1;
        chk("arst.pre_valid", 32'(cdb_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst.cdb_valid", 32'(cdb_valid), 32'd0);
        chk("arst.cdb", 32'(cdb), 32'd0);
        chk("arst.cdb_src", 32'(cdb_src), 32'd0);
        chk("arst.ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        chk("arst.hold_valid", 32'(cdb_valid), 32'd0);
        chk("arst.hold_ready", 32'(req_ready), 32'd0);
        $display("step %0d async_reset cdb_valid=%b", step, cdb_valid);
        @(negedge clk);
        rst = 1'b0; req_valid = '0;
        last_word = '0; last_src = 0;
        cyc(4'b1010, 1'b0, 4'b0010, "post_rst");

        // Random traffic: requesters hold valid until served.
        rv = '0; gr_prev = '0;
        for (int i = 0; i < N; i++) wait_c[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (gr_prev[i] || !rv[i]) rv[i] = ($urandom_range(0, 99) < 60);
                req_data[i*CDB_W +: CDB_W] = CDB_W'($urandom());
            end
            req_valid = rv;
            clear     = 1'b0;
            #1;
            rr = req_ready;
            chk("rnd.onehot0", 32'($countones(rr) <= 1), 32'd1);
            chk("rnd.subset", 32'(rr & ~rv), 32'd0);
            chk("rnd.work_conserving", 32'(|rr), 32'(|rv));
            exp_src  = 0;
            exp_word = '0;
            for (int i = 0; i < N; i++) begin
                if (rr[i]) begin
                    exp_src  = i;
                    exp_word = req_data[i*CDB_W +: CDB_W];
                end
            end
            for (int i = 1; i < N; i++) begin
                if (rv[i] && !rr[i]) wait_c[i]++;
                else wait_c[i] = 0;
                chk("rnd.starvation", 32'(wait_c[i] < BOUND), 32'd1);
            end
            gr_prev = rr;
            @(posedge clk); #1;
            chk("rnd.cdb_valid", 32'(cdb_valid), 32'(|rr));
            if (|rr) begin
                chk("rnd.cdb", 32'(cdb), 32'(exp_word));
                chk("rnd.cdb_src", 32'(cdb_src), exp_src);
            end
            if (c % 1000 == 999) $display("random cycles=%0d checks=%0d", c + 1, total);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of execution units sharing the CDB (2..8).
REQ-002 Parameter PRIO_IDX, default 0, index of the priority requester (branch unit).
REQ-003 Parameter PRIO_BURST, default 2, maximum consecutive priority grants while others wait (1..15).
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 clear  in  1  synchronous flush on branch miss.
REQ-007 req_data  in  N_REQ*CDB_W  per-requester CDB word {RSV_ID, DATA}; requester i occupies slice i.
REQ-008 req_valid  in  N_REQ  per-requester valid.
REQ-009 req_ready  out  N_REQ  per-requester ready; one-hot or zero.
REQ-010 cdb  out  CDB_W  registered broadcast word.
REQ-011 cdb_valid  out  1  registered broadcast valid.
REQ-012 cdb_src  out  N_REQ_W  index of the requester that drove the current cdb word.

Function
REQ-013 Transfer on requester i occurs when req_valid[i] and req_ready[i] are both high in the same cycle; the CDB has no backpressure.
REQ-014 req_ready is combinational from req_valid, rr_ptr, burst_cnt and clear; at most one bit high per cycle.
REQ-015 No req_valid high -> req_ready all zero; cdb_valid low next cycle.
REQ-016 PRIO_IDX valid and burst_cnt < PRIO_BURST -> grant PRIO_IDX.
REQ-017 Otherwise grant the first valid non-priority requester at or after rr_ptr, in increasing index with wrap-around N_REQ-1 -> 0.
REQ-018 PRIO_IDX valid, burst_cnt == PRIO_BURST, no other requester valid -> grant PRIO_IDX; burst_cnt stays saturated.
REQ-019 PRIO_IDX valid, burst_cnt == PRIO_BURST, another requester valid -> round-robin grant per REQ-017.
REQ-020 burst_cnt increments, saturating at PRIO_BURST, on each PRIO_IDX grant while another requester is valid; it clears to 0 on any non-priority grant or any cycle with PRIO_IDX not valid.
REQ-021 On a non-priority grant to index g, rr_ptr becomes (g+1) mod N_REQ, skipping PRIO_IDX; on a priority grant rr_ptr is unchanged.
REQ-022 Latency: a granted word appears on cdb, with cdb_valid=1 and cdb_src=g, exactly one cycle after the transfer; throughput is one word per cycle.
REQ-023 cdb and cdb_src hold their last value when cdb_valid=0.
REQ-024 Starvation bound: a continuously valid non-priority requester is granted within (N_REQ-1)*(PRIO_BURST+1) cycles.
REQ-025 clear high -> req_ready all zero in that cycle; next cycle cdb_valid=0, rr_ptr=first non-priority index, burst_cnt=0.
REQ-026 A transfer registered in the cycle before clear is still broadcast during the clear cycle.

Reset
REQ-027 rst asserted -> immediately cdb_valid=0, cdb=0, cdb_src=0, rr_ptr=first non-priority index, burst_cnt=0, independent of clk.
REQ-028 While rst is high, req_ready is all zero.
REQ-029 A word in flight when rst asserts is discarded and not broadcast.

Structure
REQ-030 CDB_W, RSV_ID_W and DATA_W come from fcpu_pkg; N_REQ_W = $clog2(N_REQ) is a local parameter.
REQ-031 The round-robin search is one sub-module, rr_pick (request mask, pointer -> one-hot grant); the output register and burst counter stay in cdb_arbiter.

Verification
REQ-032 Reqs 1 and 3 valid, rr_ptr=1, PRIO_IDX 0 idle -> grant 1; next cycle cdb=slice1, cdb_src=1, then grant 3, then cdb_src=3.
REQ-033 Req 0 (priority) and req 2 continuously valid, PRIO_BURST=2 -> grant sequence 0,0,2,0,0,2.
REQ-034 Only req 0 valid for 5 cycles -> 5 grants to 0, five consecutive cdb_valid pulses, burst_cnt stays 0.
REQ-035 Transfer at cycle t, clear at t+1 with all reqs valid -> cdb_valid=1 at t+1, req_ready=0 at t+1, cdb_valid=0 at t+2.
REQ-036 rst asserted asynchronously between edges while cdb_valid=1 -> cdb_valid drops before the next edge, and no grant occurs until rst is released.
REQ-037 Random req_valid for 10k cycles -> per-cycle checks: req_ready one-hot-or-zero, REQ-024 bound holds, scoreboard matches every transfer to exactly one cdb word.
